// File: rtl/jk_seq_pkg.sv
// Shared op/state encodings and the op-to-J/K mapping for the JK latch command sequencer.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4
    } state_e;

    // Returns {J, K} for a command.
    function automatic logic [1:0] jk_of(input op_e op);
        logic [1:0] jk;
        case (op)
            OP_RESET:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_seq_timer.sv
// Loadable down-counter: load a count on state entry, expired while the count is zero.
// Holds at zero rather than wrapping.
module jk_seq_timer #(
    parameter int unsigned W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Drives J/K/En of a JK latch through setup/pulse/settle/check per command and tracks expected Q.
// JK_SEQ_CHECK_EN builds in the sticky Q-mismatch flag; otherwise err is tied low.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned EN_PULSE = 2,
    parameter int unsigned SETTLE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       J,
    output logic       K,
    output logic       En,
    input  logic       q_in,
    output logic       done,
    output logic       q_known,
    output logic       err
);

    localparam int unsigned TMAX = (EN_PULSE > SETTLE) ? EN_PULSE : SETTLE;
    localparam int unsigned TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

    // Loaded values are one less than the stay length: the entry cycle counts.
    localparam logic [TW-1:0] PULSE_LD  = TW'(EN_PULSE - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);

    state_e        r_state, w_state_nxt;
    op_e           r_op;
    logic          r_j, r_k, r_en, r_done, r_ready;
    logic          r_exp_q, r_q_known;
    logic          w_accept;
    logic          w_tmr_load, w_tmr_expired;
    logic [TW-1:0] w_tmr_value;
    logic [1:0]    w_jk_nxt;
    logic          w_en_nxt, w_done_nxt, w_ready_nxt;
    logic          w_exp_q_nxt, w_q_known_nxt;

    assign w_accept = cmd_valid && r_ready;

    jk_seq_timer #(.W(TW)) u_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_HOLD;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op <= op_e'(cmd_op);
            end
        end
    end

    // Outputs are registered from the current state, so they trail the state by one cycle;
    // ready is the exception and drops on the accept edge itself.
    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_load    = 1'b0;
        w_tmr_value   = '0;
        w_jk_nxt      = 2'b00;
        w_en_nxt      = 1'b0;
        w_done_nxt    = 1'b0;
        w_ready_nxt   = 1'b0;
        w_exp_q_nxt   = r_exp_q;
        w_q_known_nxt = r_q_known;
        case (r_state)
            ST_IDLE: begin
                w_ready_nxt = !w_accept;
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_jk_nxt   = jk_of(r_op);
                w_tmr_load = 1'b1;
                if (r_op == OP_HOLD) begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_value = SETTLE_LD;
                end else begin
                    w_state_nxt = ST_PULSE;
                    w_tmr_value = (r_op == OP_TOGGLE) ? '0 : PULSE_LD;
                end
            end
            ST_PULSE: begin
                w_jk_nxt = jk_of(r_op);
                w_en_nxt = 1'b1;
                if (w_tmr_expired) begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                w_jk_nxt = jk_of(r_op);
                if (w_tmr_expired) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
                case (r_op)
                    OP_RESET: begin
                        w_exp_q_nxt   = 1'b0;
                        w_q_known_nxt = 1'b1;
                    end
                    OP_SET: begin
                        w_exp_q_nxt   = 1'b1;
                        w_q_known_nxt = 1'b1;
                    end
                    OP_TOGGLE: begin
                        if (r_q_known) begin
                            w_exp_q_nxt = ~r_exp_q;
                        end
                    end
                    default: ;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_j       <= 1'b0;
            r_k       <= 1'b0;
            r_en      <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
            r_exp_q   <= 1'b0;
            r_q_known <= 1'b0;
        end else begin
            r_j       <= w_jk_nxt[1];
            r_k       <= w_jk_nxt[0];
            r_en      <= w_en_nxt;
            r_done    <= w_done_nxt;
            r_ready   <= w_ready_nxt;
            r_exp_q   <= w_exp_q_nxt;
            r_q_known <= w_q_known_nxt;
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic r_err;
    logic w_mismatch;

    assign w_mismatch = (r_state == ST_CHECK) && w_q_known_nxt && (q_in != w_exp_q_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    // Readback is only compared when checking is built in.
    assign err = q_in & 1'b0;
`endif

    assign cmd_ready = r_ready;
    assign J         = r_j;
    assign K         = r_k;
    assign En        = r_en;
    assign done      = r_done;
    assign q_known   = r_q_known;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer driving a behavioural JK latch load.
module tb_jk_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready, J, K, En, done, q_known, err;
    logic       q_in;
    logic       lq = 1'b0;
    logic       force_q0 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef JK_SEQ_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    // Latch load: J/K applied whenever En is high at a clock edge.
    always @(posedge clk) begin
        if (En) begin
            if (J && K)  lq <= ~lq;
            else if (J)  lq <= 1'b1;
            else if (K)  lq <= 1'b0;
        end
    end

    assign q_in = force_q0 ? 1'b0 : lq;

    jk_cmd_sequencer #(.EN_PULSE(2), .SETTLE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .J         (J),
        .K         (K),
        .En        (En),
        .q_in      (q_in),
        .done      (done),
        .q_known   (q_known),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Issues one command and measures it up to the cycle done is seen.
    task automatic run_cmd(input logic [1:0] op, input bit keep_valid, input int exp_lat,
                           input int exp_en, input logic exp_j, input logic exp_k,
                           input string tag);
        int wait_n, lat, en_n, busy_rdy;
        bit jk_bad, got;
        @(negedge clk);
        cmd_op    = op;
        cmd_valid = 1'b1;
        wait_n    = 0;
        while (!cmd_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk({tag, "_ready_wait"}, wait_n, 0);
        @(posedge clk);
        #1;
        if (!keep_valid) cmd_valid = 1'b0;
        lat = 0; en_n = 0; busy_rdy = 0; jk_bad = 1'b0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (En) begin
                en_n++;
                if (J !== exp_j || K !== exp_k) jk_bad = 1'b1;
            end
            if (cmd_ready) busy_rdy++;
            if (done) got = 1'b1;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_en_cycles"}, en_n, exp_en);
        chk({tag, "_jk_during_en"}, {31'd0, jk_bad}, 0);
        chk({tag, "_ready_busy"}, busy_rdy, 0);
    endtask

    initial begin
        int done_seen;
        #12 rst = 1'b0;
        @(negedge clk);
        chk("rst_J", J, 0);
        chk("rst_K", K, 0);
        chk("rst_En", En, 0);
        chk("rst_done", done, 0);
        chk("rst_q_known", q_known, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cmd_ready, 1);

        run_cmd(2'b10, 1'b0, 5, 2, 1'b1, 1'b0, "set1");
        chk("set1_q_in", q_in, 1);
        chk("set1_q_known", q_known, 1);
        chk("set1_err", err, 0);

        run_cmd(2'b01, 1'b0, 5, 2, 1'b0, 1'b1, "reset1");
        chk("reset1_q_in", q_in, 0);
        chk("reset1_q_known", q_known, 1);

        run_cmd(2'b11, 1'b0, 4, 1, 1'b1, 1'b1, "toggle1");
        chk("toggle1_q_in", q_in, 1);
        chk("toggle1_q_known", q_known, 1);
        chk("toggle1_err", err, 0);

        run_cmd(2'b00, 1'b0, 3, 0, 1'b0, 1'b0, "hold1");
        chk("hold1_q_in", q_in, 1);
        chk("hold1_q_known", q_known, 1);
        chk("hold1_err", err, 0);

        // Valid held through a SET: the second accept lands the cycle after done.
        run_cmd(2'b10, 1'b1, 5, 2, 1'b1, 1'b0, "held_a");
        run_cmd(2'b10, 1'b0, 5, 2, 1'b1, 1'b0, "held_b");
        chk("held_q_in", q_in, 1);

        // Abort a SET in the middle of its enable pulse.
        @(negedge clk);
        cmd_op    = 2'b10;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("abort_en_before", En, 1);
        #2 rst = 1'b1;
        #1 chk("abort_en_drop", En, 0);
        chk("abort_J_drop", J, 0);
        #8 rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_q_known", q_known, 0);
        chk("abort_ready", cmd_ready, 1);

        run_cmd(2'b10, 1'b0, 5, 2, 1'b1, 1'b0, "set2");
        chk("set2_q_known", q_known, 1);
        chk("set2_q_in", q_in, 1);
        chk("set2_err", err, 0);

        force_q0 = 1'b1;
        run_cmd(2'b10, 1'b0, 5, 2, 1'b1, 1'b0, "set_bad");
        chk("set_bad_err", err, EXP_ERR);
        force_q0 = 1'b0;

        run_cmd(2'b01, 1'b0, 5, 2, 1'b0, 1'b1, "reset2");
        chk("reset2_q_in", q_in, 0);
        chk("reset2_err_sticky", err, EXP_ERR);

        run_cmd(2'b11, 1'b0, 4, 1, 1'b1, 1'b1, "toggle2");
        chk("toggle2_q_in", q_in, 1);
        chk("toggle2_err_sticky", err, EXP_ERR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
